// File: rtl/rt_pkg.sv
// Shared definitions for the route-computation stage: port indices, FSM states
// and the XY / VC selection helpers used by the top and the multicast splitter.
package rt_pkg;

    localparam int NPORT = 5;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_EAST  = 3'd1;
    localparam logic [2:0] P_WEST  = 3'd2;
    localparam logic [2:0] P_NORTH = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FORK = 1'b1
    } rt_state_e;

    // X first, then Y; a destination equal to this node stays LOCAL.
    function automatic logic [2:0] xy_port(input int my_x, input int my_y,
                                           input int dst_x, input int dst_y);
        logic [2:0] p;
        if (dst_x > my_x) begin
            p = P_EAST;
        end else if (dst_x < my_x) begin
            p = P_WEST;
        end else if (dst_y > my_y) begin
            p = P_NORTH;
        end else if (dst_y < my_y) begin
            p = P_SOUTH;
        end else begin
            p = P_LOCAL;
        end
        return p;
    endfunction

    function automatic int vc_next(input int vch, input int iport, input int oport,
                                   input int policy, input int nvch);
        logic turn;
        int   res;
        turn = ((iport == int'(P_EAST)) || (iport == int'(P_WEST))) &&
               ((oport == int'(P_NORTH)) || (oport == int'(P_SOUTH)));
        if ((policy == 1) && turn) begin
            res = (vch + 1) % nvch;
        end else begin
            res = vch;
        end
        return res;
    endfunction

    // Lowest set bit wins, so branches leave in port-index order.
    function automatic logic [2:0] low_idx(input logic [NPORT-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            idx = m[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic one_left(input logic [NPORT-1:0] m);
        return (m != 5'd0) && ((m & (m - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/rtcomp_mc_if.sv
// Header-in / branch-out channel of the route-computation stage.
interface rtcomp_mc_if #(
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4,
    parameter int NVCH   = 2
);
    localparam int NNODE = MESH_X * MESH_Y;
    localparam int XW    = (MESH_X > 1) ? $clog2(MESH_X) : 1;
    localparam int YW    = (MESH_Y > 1) ? $clog2(MESH_Y) : 1;
    localparam int VW    = (NVCH > 1) ? $clog2(NVCH) : 1;

    logic             hdr_valid;
    logic             hdr_ready;
    logic             hdr_um;
    logic [XW-1:0]    hdr_dst_x;
    logic [YW-1:0]    hdr_dst_y;
    logic [NNODE-1:0] hdr_mdst;
    logic [VW-1:0]    hdr_vch;
    logic [2:0]       hdr_iport;
    logic             rt_valid;
    logic             rt_ready;
    logic [4:0]       rt_port;
    logic [VW-1:0]    rt_ovch;
    logic [NNODE-1:0] rt_mdst_rm;
    logic             rt_last;
    logic             rt_drop;

    modport slave (
        input  hdr_valid, hdr_um, hdr_dst_x, hdr_dst_y, hdr_mdst, hdr_vch, hdr_iport,
        input  rt_ready,
        output hdr_ready,
        output rt_valid, rt_port, rt_ovch, rt_mdst_rm, rt_last, rt_drop
    );

    modport master (
        output hdr_valid, hdr_um, hdr_dst_x, hdr_dst_y, hdr_mdst, hdr_vch, hdr_iport,
        output rt_ready,
        input  hdr_ready,
        input  rt_valid, rt_port, rt_ovch, rt_mdst_rm, rt_last, rt_drop
    );

endinterface

// File: rtl/rt_mc_split.sv
// Combinational partition of a multicast bitmap into one destination bitmap
// per output port, plus the mask of ports that receive at least one destination.
module rt_mc_split
    import rt_pkg::*;
#(
    parameter int MESH_X  = 4,
    parameter int MESH_Y  = 4,
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0
) (
    input  logic [MESH_X*MESH_Y-1:0]            mdst,
    output logic [NPORT-1:0][MESH_X*MESH_Y-1:0] bm,
    output logic [NPORT-1:0]                    pend
);

    localparam int NNODE = MESH_X * MESH_Y;

    logic [2:0] port_s;

    // Route every node index with the XY rule and collect its bit under that port.
    always_comb begin
        bm     = '0;
        pend   = '0;
        port_s = 3'd0;
        for (int n = 0; n < NNODE; n++) begin
            port_s        = xy_port(MY_XPOS, MY_YPOS, n % MESH_X, n / MESH_X);
            bm[port_s][n] = mdst[n];
        end
        for (int p = 0; p < NPORT; p++) begin
            pend[p] = |bm[p];
        end
    end

endmodule

// File: rtl/rtcomp_mc.sv
// Pipelined XY route computation with bitmap multicast: one header in, one
// branch per destination port out, emitted lowest port first under backpressure.
module rtcomp_mc
    import rt_pkg::*;
#(
    parameter int MESH_X    = 4,
    parameter int MESH_Y    = 4,
    parameter int MY_XPOS   = 0,
    parameter int MY_YPOS   = 0,
    parameter int NVCH      = 2,
    parameter int VC_POLICY = 0
) (
    input  logic        clk,
    input  logic        rst,
    rtcomp_mc_if.slave  bus
);

    localparam int NNODE = MESH_X * MESH_Y;
    localparam int VW    = (NVCH > 1) ? $clog2(NVCH) : 1;

    rt_state_e                     state_r;
    rt_state_e                     state_n_s;

    logic [NPORT-1:0][NNODE-1:0]   split_bm_s;
    logic [NPORT-1:0]              split_pend_s;
    logic [2:0]                    uni_port_s;

    logic [NPORT-1:0][NNODE-1:0]   bm_r,    bm_n_s;
    logic [NPORT-1:0]              pend_r,  pend_n_s;
    logic [VW-1:0]                 vch_r,   vch_n_s;
    logic [2:0]                    iport_r, iport_n_s;
    logic                          um_r,    um_n_s;
    logic                          drop_r,  drop_n_s;

    logic                          valid_r;
    logic [4:0]                    port_r,  port_n_s;
    logic [VW-1:0]                 ovch_r,  ovch_n_s;
    logic [NNODE-1:0]              mdst_r,  mdst_n_s;
    logic                          last_r,  last_n_s;
    logic                          rdrop_r;

    logic [2:0]                    sel_idx_s;
    logic                          load_out_s;
    logic                          accept_s;
    logic                          take_s;
    logic                          hdr_ready_s;
    logic                          rt_valid_s;

    rt_mc_split #(
        .MESH_X  (MESH_X),
        .MESH_Y  (MESH_Y),
        .MY_XPOS (MY_XPOS),
        .MY_YPOS (MY_YPOS)
    ) u_split (
        .mdst (bus.hdr_mdst),
        .bm   (split_bm_s),
        .pend (split_pend_s)
    );

    assign uni_port_s = xy_port(MY_XPOS, MY_YPOS, int'(bus.hdr_dst_x), int'(bus.hdr_dst_y));
    assign accept_s   = bus.hdr_valid & hdr_ready_s;
    assign take_s     = valid_r & bus.rt_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next state: stay in FORK while any branch remains after this edge.
    always_comb begin
        state_n_s = state_r;
        if (accept_s || take_s) begin
            state_n_s = (pend_n_s != 5'd0) ? ST_FORK : ST_IDLE;
        end else begin
            state_n_s = state_r;
        end
    end

    // FSM outputs; a new header may ride on the handshake of the final branch.
    always_comb begin
        hdr_ready_s = 1'b0;
        if (rst) begin
            hdr_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: hdr_ready_s = 1'b1;
                ST_FORK: hdr_ready_s = last_r & bus.rt_ready;
                default: hdr_ready_s = 1'b0;
            endcase
        end
        rt_valid_s = valid_r & ~rst;
    end

    // Next header context and next branch to present; loaded header beats a consumed branch.
    always_comb begin
        bm_n_s     = bm_r;
        pend_n_s   = pend_r;
        vch_n_s    = vch_r;
        iport_n_s  = iport_r;
        um_n_s     = um_r;
        drop_n_s   = drop_r;
        load_out_s = 1'b0;
        if (accept_s) begin
            load_out_s = 1'b1;
            vch_n_s    = bus.hdr_vch;
            iport_n_s  = bus.hdr_iport;
            um_n_s     = bus.hdr_um;
            if (bus.hdr_um) begin
                bm_n_s   = split_bm_s;
                drop_n_s = (split_pend_s == 5'd0);
                // An empty bitmap still produces a single terminating branch.
                pend_n_s = drop_n_s ? 5'b00001 : split_pend_s;
            end else begin
                bm_n_s   = '0;
                drop_n_s = 1'b0;
                pend_n_s = 5'b00001 << uni_port_s;
            end
        end else if (take_s) begin
            load_out_s = 1'b1;
            pend_n_s   = pend_r & ~(5'b00001 << low_idx(pend_r));
        end else begin
            load_out_s = 1'b0;
        end
        sel_idx_s = low_idx(pend_n_s);
        port_n_s  = drop_n_s ? 5'b00000 : (5'b00001 << sel_idx_s);
        ovch_n_s  = VW'(vc_next(int'(vch_n_s), int'(iport_n_s), int'(sel_idx_s), VC_POLICY, NVCH));
        mdst_n_s  = um_n_s ? bm_n_s[sel_idx_s] : '0;
        last_n_s  = one_left(pend_n_s);
    end

    // Header context and registered branch outputs; port/vc/bitmap hold after the last branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            bm_r    <= '0;
            pend_r  <= 5'd0;
            vch_r   <= '0;
            iport_r <= 3'd0;
            um_r    <= 1'b0;
            drop_r  <= 1'b0;
            valid_r <= 1'b0;
            port_r  <= 5'd0;
            ovch_r  <= '0;
            mdst_r  <= '0;
            last_r  <= 1'b0;
            rdrop_r <= 1'b0;
        end else begin
            bm_r    <= bm_n_s;
            pend_r  <= pend_n_s;
            vch_r   <= vch_n_s;
            iport_r <= iport_n_s;
            um_r    <= um_n_s;
            drop_r  <= drop_n_s;
            if (load_out_s) begin
                valid_r <= (pend_n_s != 5'd0);
                if (pend_n_s != 5'd0) begin
                    port_r  <= port_n_s;
                    ovch_r  <= ovch_n_s;
                    mdst_r  <= mdst_n_s;
                    last_r  <= last_n_s;
                    rdrop_r <= drop_n_s;
                end else begin
                    last_r  <= 1'b0;
                    rdrop_r <= 1'b0;
                end
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign bus.hdr_ready  = hdr_ready_s;
    assign bus.rt_valid   = rt_valid_s;
    assign bus.rt_port    = port_r;
    assign bus.rt_ovch    = ovch_r;
    assign bus.rt_mdst_rm = mdst_r;
    assign bus.rt_last    = last_r;
    assign bus.rt_drop    = rdrop_r;

endmodule

// File: tb/tb_rtcomp_mc.sv
// Directed bench for rtcomp_mc on a 4x4 mesh at node (1,1) with the turn VC policy.
module tb_rtcomp_mc;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    rtcomp_mc_if #(.MESH_X(4), .MESH_Y(4), .NVCH(2)) bus ();

    rtcomp_mc #(
        .MESH_X    (4),
        .MESH_Y    (4),
        .MY_XPOS   (1),
        .MY_YPOS   (1),
        .NVCH      (2),
        .VC_POLICY (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hdr(input logic um, input logic [1:0] dx, input logic [1:0] dy,
                           input logic [15:0] mdst, input logic vch, input logic [2:0] iport);
        bus.hdr_um    = um;
        bus.hdr_dst_x = dx;
        bus.hdr_dst_y = dy;
        bus.hdr_mdst  = mdst;
        bus.hdr_vch   = vch;
        bus.hdr_iport = iport;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b1;
        bus.hdr_valid = 1'b0;
        bus.rt_ready  = 1'b0;
        set_hdr(1'b0, 2'd0, 2'd0, 16'h0000, 1'b0, 3'd0);

        // reset state
        tick();
        chk("rst_hdr_ready", 32'(bus.hdr_ready), 32'h0);
        chk("rst_valid",     32'(bus.rt_valid),  32'h0);
        chk("rst_port",      32'(bus.rt_port),   32'h0);
        chk("rst_ovch",      32'(bus.rt_ovch),   32'h0);
        chk("rst_mdst",      32'(bus.rt_mdst_rm), 32'h0);
        chk("rst_last",      32'(bus.rt_last),   32'h0);
        chk("rst_drop",      32'(bus.rt_drop),   32'h0);
        rst = 1'b0;
        #1;
        chk("idle_hdr_ready", 32'(bus.hdr_ready), 32'h1);

        // unicast to (3,1), vch 1
        set_hdr(1'b0, 2'd3, 2'd1, 16'h0000, 1'b1, 3'd0);
        bus.hdr_valid = 1'b1;
        #1;
        chk("uc_pre_valid", 32'(bus.rt_valid), 32'h0);
        tick();
        bus.hdr_valid = 1'b0;
        bus.hdr_dst_x = 2'd0;
        #1;
        chk("uc_valid", 32'(bus.rt_valid),   32'h1);
        chk("uc_port",  32'(bus.rt_port),    32'h02);
        chk("uc_ovch",  32'(bus.rt_ovch),    32'h1);
        chk("uc_last",  32'(bus.rt_last),    32'h1);
        chk("uc_mdst",  32'(bus.rt_mdst_rm), 32'h0);
        chk("uc_drop",  32'(bus.rt_drop),    32'h0);
        chk("uc_hdr_ready_lo", 32'(bus.hdr_ready), 32'h0);
        bus.rt_ready = 1'b1;
        #1;
        chk("uc_hdr_ready_hi", 32'(bus.hdr_ready), 32'h1);
        tick();
        bus.rt_ready = 1'b0;
        #1;
        chk("uc_done_valid", 32'(bus.rt_valid), 32'h0);
        chk("uc_hold_port",  32'(bus.rt_port),  32'h02);
        chk("uc_hold_ovch",  32'(bus.rt_ovch),  32'h1);

        // multicast {4,5,7,13}: LOCAL, EAST, WEST, NORTH
        set_hdr(1'b1, 2'd0, 2'd0, 16'h20B0, 1'b0, 3'd0);
        bus.hdr_valid = 1'b1;
        bus.rt_ready  = 1'b1;
        tick();
        bus.hdr_valid = 1'b0;
        bus.hdr_mdst  = 16'hFFFF;
        #1;
        chk("mc0_valid", 32'(bus.rt_valid),   32'h1);
        chk("mc0_port",  32'(bus.rt_port),    32'h01);
        chk("mc0_mdst",  32'(bus.rt_mdst_rm), 32'h0020);
        chk("mc0_last",  32'(bus.rt_last),    32'h0);
        tick();
        chk("mc1_port",  32'(bus.rt_port),    32'h02);
        chk("mc1_mdst",  32'(bus.rt_mdst_rm), 32'h0080);
        chk("mc1_last",  32'(bus.rt_last),    32'h0);
        bus.rt_ready = 1'b0;
        tick();
        chk("mc1_stall1_valid", 32'(bus.rt_valid),   32'h1);
        chk("mc1_stall1_port",  32'(bus.rt_port),    32'h02);
        chk("mc1_stall1_mdst",  32'(bus.rt_mdst_rm), 32'h0080);
        tick();
        chk("mc1_stall2_port",  32'(bus.rt_port),    32'h02);
        chk("mc1_stall2_mdst",  32'(bus.rt_mdst_rm), 32'h0080);
        bus.rt_ready = 1'b1;
        tick();
        chk("mc2_port",  32'(bus.rt_port),    32'h04);
        chk("mc2_mdst",  32'(bus.rt_mdst_rm), 32'h0010);
        chk("mc2_last",  32'(bus.rt_last),    32'h0);
        tick();
        chk("mc3_port",  32'(bus.rt_port),    32'h08);
        chk("mc3_mdst",  32'(bus.rt_mdst_rm), 32'h2000);
        chk("mc3_last",  32'(bus.rt_last),    32'h1);
        chk("mc3_ovch",  32'(bus.rt_ovch),    32'h0);
        tick();
        bus.rt_ready = 1'b0;
        #1;
        chk("mc_done_valid", 32'(bus.rt_valid),   32'h0);
        chk("mc_hold_mdst",  32'(bus.rt_mdst_rm), 32'h2000);

        // empty multicast bitmap
        set_hdr(1'b1, 2'd0, 2'd0, 16'h0000, 1'b0, 3'd0);
        bus.hdr_valid = 1'b1;
        tick();
        bus.hdr_valid = 1'b0;
        #1;
        chk("drop_valid", 32'(bus.rt_valid),   32'h1);
        chk("drop_port",  32'(bus.rt_port),    32'h00);
        chk("drop_drop",  32'(bus.rt_drop),    32'h1);
        chk("drop_last",  32'(bus.rt_last),    32'h1);
        chk("drop_mdst",  32'(bus.rt_mdst_rm), 32'h0);
        bus.rt_ready = 1'b1;
        tick();
        bus.rt_ready = 1'b0;
        #1;
        chk("drop_done_valid", 32'(bus.rt_valid),  32'h0);
        chk("drop_idle_ready", 32'(bus.hdr_ready), 32'h1);

        // X->Y turn from EAST, then back-to-back header from SOUTH
        set_hdr(1'b0, 2'd1, 2'd3, 16'h0000, 1'b1, 3'd1);
        bus.hdr_valid = 1'b1;
        bus.rt_ready  = 1'b1;
        tick();
        set_hdr(1'b0, 2'd1, 2'd3, 16'h0000, 1'b1, 3'd4);
        #1;
        chk("turn_port",  32'(bus.rt_port),   32'h08);
        chk("turn_ovch",  32'(bus.rt_ovch),   32'h0);
        chk("b2b_hdr_ready", 32'(bus.hdr_ready), 32'h1);
        tick();
        bus.hdr_valid = 1'b0;
        #1;
        chk("b2b_valid", 32'(bus.rt_valid), 32'h1);
        chk("b2b_port",  32'(bus.rt_port),  32'h08);
        chk("noturn_ovch", 32'(bus.rt_ovch), 32'h1);
        tick();
        chk("b2b_done_valid", 32'(bus.rt_valid), 32'h0);

        // reset in FORK with two branches pending
        bus.rt_ready = 1'b0;
        set_hdr(1'b1, 2'd0, 2'd0, 16'h00B0, 1'b0, 3'd0);
        bus.hdr_valid = 1'b1;
        tick();
        bus.hdr_valid = 1'b0;
        #1;
        chk("rf0_port", 32'(bus.rt_port), 32'h01);
        bus.rt_ready = 1'b1;
        tick();
        bus.rt_ready = 1'b0;
        #1;
        chk("rf1_valid", 32'(bus.rt_valid), 32'h1);
        chk("rf1_port",  32'(bus.rt_port),  32'h02);
        rst = 1'b1;
        #1;
        chk("rf_rst_valid", 32'(bus.rt_valid),  32'h0);
        chk("rf_rst_ready", 32'(bus.hdr_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rf_post_ready", 32'(bus.hdr_ready), 32'h1);
        chk("rf_post_valid", 32'(bus.rt_valid),  32'h0);
        chk("rf_post_port",  32'(bus.rt_port),   32'h00);
        bus.rt_ready = 1'b1;
        tick();
        chk("rf_stale1_valid", 32'(bus.rt_valid), 32'h0);
        tick();
        chk("rf_stale2_valid", 32'(bus.rt_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rtcomp_mc.md
# rtcomp_mc

Parametrised, pipelined route-computation stage for the mesh router input port, supporting unicast and bitmap multicast. It accepts one header per handshake and computes XY dimension-order routes. A multicast header is split into per-output-port branches, each carrying the subset of destinations it serves, and the branches are emitted one per cycle under valid/ready backpressure. It sits between the input VC buffer and the switch/VC allocators, and replaces the single-cycle hold-register route computation used up to now.

## Interface
- MESH_X, 4: mesh columns.
- MESH_Y, 4: mesh rows.
- MY_XPOS, 0: this node's x coordinate.
- MY_YPOS, 0: this node's y coordinate.
- NVCH, 2: virtual channels per port.
- VC_POLICY, 0: 0 = output VC equals input VC; 1 = VC increments mod NVCH on an X→Y turn.
- Derived values:
  - NNODE = MESH_X*MESH_Y.
  - XW = max(1, clog2(MESH_X)); YW likewise from MESH_Y.
  - VW = max(1, clog2(NVCH)).

Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- hdr_valid  in  1  header present.
- hdr_ready  out  1  header accepted when high together with hdr_valid.
- hdr_um  in  1  0 = unicast, 1 = multicast.
- hdr_dst_x  in  XW  unicast destination x.
- hdr_dst_y  in  YW  unicast destination y.
- hdr_mdst  in  NNODE  multicast destination bitmap; bit n = node y*MESH_X+x.
- hdr_vch  in  VW  input VC.
- hdr_iport  in  3  arrival port index.
- rt_valid  out  1  branch result valid.
- rt_ready  in  1  consumer takes the branch.
- rt_port  out  5  one-hot output port.
- rt_ovch  out  VW  output VC.
- rt_mdst_rm  out  NNODE  destinations served by this branch; 0 for unicast.
- rt_last  out  1  final branch of the current header.
- rt_drop  out  1  multicast with an empty bitmap.

## Operation
- Port indices: 0 LOCAL, 1 EAST (+x), 2 WEST (−x), 3 NORTH (+y), 4 SOUTH (−y).
- XY routing rule, applied per destination:
  - dst_x > MY_XPOS → EAST; dst_x < MY_XPOS → WEST.
  - Otherwise dst_y > MY_YPOS → NORTH; dst_y < MY_YPOS → SOUTH.
  - Otherwise LOCAL.
- Unicast: exactly one branch; rt_mdst_rm = 0; rt_last = 1.
- Multicast:
  - Every set bit of hdr_mdst is routed with the XY rule.
  - Per-port branch bitmap = OR of the bits routed to that port.
  - pend_mask[p] = (branch bitmap p nonzero).
- Empty multicast bitmap produces one branch: rt_port = 0, rt_drop = 1, rt_last = 1.
- VC selection:
  - turn = (hdr_iport ∈ {EAST, WEST}) and (branch port ∈ {NORTH, SOUTH}).
  - VC_POLICY=1 and turn: rt_ovch = (hdr_vch+1) mod NVCH.
  - Otherwise rt_ovch = hdr_vch.
  - The VC is computed per branch.
- FSM with two states:
  - IDLE: hdr_ready = 1. On hdr_valid, latch the branch bitmaps, pend_mask, VC and flags, then go to FORK.
  - FORK:
    - rt_valid = 1; the presented branch is the lowest set bit of pend_mask.
    - rt_last = 1 when exactly one bit remains.
    - On rt_ready, clear that bit; if it was the last, return to IDLE.
- Back-to-back headers: in FORK, hdr_ready = rt_last & rt_ready. Accepting in that cycle loads the new header and stays in FORK.
- Backpressure: while rt_valid & !rt_ready, every rt_* output is stable.
- After the final branch, rt_port, rt_ovch and rt_mdst_rm hold their last values with rt_valid = 0, until the next header loads.
- hdr_* inputs are sampled only on acceptance; later changes are ignored.

## Timing
- Header accepted at edge N → first branch valid after edge N (rt_valid high in cycle N+1).
- Branch k (0-based) is visible no earlier than cycle N+1+k.
- Peak throughput: one branch per cycle; no bubble between headers when back-to-back acceptance applies.
- Reset values: rt_valid, rt_port, rt_ovch, rt_mdst_rm, rt_last, rt_drop = 0; hdr_ready = 0 in the reset cycle; state = IDLE; pend_mask = 0.
- rst asserted mid-FORK: pending branches are discarded at the next edge, and hdr_ready = 1 from the first cycle after rst deasserts.
- hdr_ready depends combinationally on rt_ready only in FORK; there is no combinational path from hdr_* to rt_*.

## Structure
- Package rt_pkg holds:
  - Port index constants and NPORT = 5.
  - Function xy_port(my_x, my_y, dst_x, dst_y).
  - Function vc_next(vch, iport, oport, policy).
- Sub-module rt_mc_split: combinational partition of hdr_mdst into NPORT branch bitmaps plus pend_mask, parametrised by MESH_X, MESH_Y, MY_XPOS, MY_YPOS.
- Top level contains the FSM, latch registers and lowest-bit priority select.

## Test plan
All scenarios use MESH_X=MESH_Y=4 and node (1,1), index 5.
- Unicast to (3,1), vch 1: rt_valid in the cycle after acceptance; rt_port = 00010, rt_ovch = 1, rt_last = 1, rt_mdst_rm = 0.
- Multicast hdr_mdst with bits {4,5,7,13}:
  - Four branches in order: LOCAL{5}, EAST{7}, WEST{4}, NORTH{13}.
  - rt_last only on NORTH.
  - rt_ready held low 2 cycles on EAST → outputs stable, no skip.
- Multicast with hdr_mdst = 0: one branch with rt_port = 0, rt_drop = 1, rt_last = 1, then IDLE.
- VC_POLICY=1, NVCH=2, destination (1,3):
  - iport EAST, vch 1 → NORTH, rt_ovch = 0.
  - iport SOUTH, vch 1 → rt_ovch = 1.
- Second header valid during the first header's last branch with rt_ready = 1: hdr_ready = 1 that cycle, and the new first branch appears the next cycle with no bubble.
- rst pulsed one cycle in FORK with 2 branches pending: rt_valid = 0 and hdr_ready = 0 in the reset cycle; hdr_ready = 1 after; no stale branch emitted.
